writeback_ctrl: RTL
===================

# writeback_ctrl

Write-port master for the integer register file. It merges single-cycle ALU results with out-of-order load responses from the LSU into the register file's one write port. Load responses go through a small FIFO, and a bounded-starvation arbiter selects between the two sources. It also keeps a per-register pending-load scoreboard, which the issue stage uses for RAW/WAW interlocks. It sits between execute/LSU and the register file's we/rd/rd_data inputs.

## Interface
- DEPTH, 2: load-response FIFO entries (≥1).
- STARVE_LIMIT, 4: consecutive cycles a non-empty load FIFO may lose to the ALU before the load is forced through (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  ALU result is consumed this cycle when alu_valid && alu_ready.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_issue_valid  in  1  load issued this cycle; marks ld_issue_rd pending.
- ld_issue_rd  in  5  destination of the issued load.
- ld_resp_valid  in  1  LSU load data valid.
- ld_resp_ready  out  1  FIFO can accept a response.
- ld_resp_rd  in  5  load destination register.
- ld_resp_data  in  32  load data.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file write index (registered).
- rf_rd_data  out  32  register-file write data (registered).
- busy  out  32  scoreboard; busy[i]=1 means a load to xi is outstanding. busy[0] is constant 0.

## Operation
- **Load accept.** A load response is accepted when ld_resp_valid && ld_resp_ready.
  - Accepted entries with rd≠0 are enqueued.
  - Accepted entries with rd=0 are dropped, but the handshake still completes.
- **Flow control.** ld_resp_ready = (count < DEPTH), driven from registered count only. When the FIFO is full, ready is 0 even if a pop happens in the same cycle.
- **Arbitration.** Evaluated each cycle; the winner drives the rf_* registers at the next edge.
  - force = (FIFO non-empty) && (starve_cnt == STARVE_LIMIT).
  - alu_ready = !force.
  - If alu_valid && alu_ready, the ALU wins. rf_we ← (alu_rd≠0), rf_rd ← alu_rd, rf_rd_data ← alu_data.
  - Otherwise, if the FIFO is non-empty, the head is popped and written: rf_we ← 1, head rd/data.
  - Otherwise rf_we ← 0; rf_rd and rf_rd_data hold their previous values.
- **starve_cnt** (width clog2(STARVE_LIMIT+1)):
  - Resets to 0 when the FIFO is empty or a FIFO entry wins.
  - Increments, saturating at STARVE_LIMIT, when the ALU wins while the FIFO is non-empty.
- **Simultaneous push and pop.** Both are allowed and count is unchanged. A response pushed into an empty FIFO cannot be popped in the same cycle (no bypass).
- **Scoreboard.**
  - Set: busy[ld_issue_rd] ← 1 on ld_issue_valid with rd≠0.
  - Clear: busy[rf_rd] ← 0 at the edge that ends a cycle in which rf_we=1 from a load write. This is the same edge at which the register file commits the data.
  - If a set and a clear hit the same index in the same cycle, set wins.
  - ALU writes never touch busy.
- **Issue-stage preconditions.** The issue stage guarantees it never issues an ALU op or a load to a busy register. The block does not check this.
- **Reset.** While rst is high and on the cycle it deasserts:
  - FIFO emptied, starve_cnt=0, busy=0, rf_we=0, rf_rd=0, rf_rd_data=0.
  - ld_resp_ready=0 and alu_ready=0 while rst=1.
  - Reset mid-operation drops all queued and outstanding loads.

## Timing
- ALU path: alu handshake in cycle N → rf_we=1 in cycle N+1 → register file written at the end of N+1.
- Load path, uncontended: accepted in N → popped in N+1 → rf_we=1 in N+2 → busy bit low from N+3.
- Worst-case wait for the FIFO head under continuous ALU traffic: STARVE_LIMIT cycles, then one forced load cycle with alu_ready=0.
- Throughput: one register-file write per cycle. ld_resp_ready has no combinational dependence on alu_valid or ld_resp_valid.

## Test plan
- **Reset.** Assert rst for 3 cycles with random inputs.
  - → rf_we=0, rf_rd=0, rf_rd_data=0, busy=0, both ready signals 0.
  - → ld_resp_ready=1 on the first cycle after release.
- **ALU write.** alu_valid, rd=5, data=0xDEADBEEF in cycle N.
  - → rf_we=1, rf_rd=5, rf_rd_data=0xDEADBEEF in N+1.
  - With rd=0 instead → rf_we=0 and alu_ready=1.
- **Load and scoreboard.** Issue a load to x7 in cycle N, then respond with 0x12345678 in N+2.
  - → busy[7]=1 from N+1.
  - → rf_we=1, rf_rd=7 in N+4.
  - → busy[7]=0 in N+5.
- **Full FIFO.** DEPTH=2. Hold alu_valid=1 continuously and send 3 back-to-back load responses.
  - → ld_resp_ready=0 after 2 accepts.
  - → Over the next cycles: 4 ALU writes, then alu_ready=0 for 1 cycle and a load write, then 4 ALU writes and the second load.
- **Set/clear collision.** A load to x3 writes back in the same cycle a new load to x3 issues.
  - → busy[3] remains 1.
- **Reset mid-flight.** Assert rst with 2 FIFO entries and busy=0x0000_0088.
  - → FIFO empty, busy=0, no rf_we after release.

Source files
------------

// File: rtl/writeback_ctrl.sv
// writeback_ctrl
//
// Write-port master for the integer register file. Single-cycle ALU results
// and out-of-order load responses share the register file's one write port.
// Load responses wait in a small FIFO. A bounded-starvation arbiter favours
// the ALU, but forces the FIFO head through after STARVE_LIMIT lost cycles.
// A per-register scoreboard (busy) tracks outstanding loads for the issue
// stage's RAW/WAW interlocks.
//
// Parameters:
//   DEPTH         load-response FIFO entries (>= 1)
//   STARVE_LIMIT  cycles a non-empty FIFO may lose to the ALU (>= 1)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   alu_valid/ready   ALU result handshake; alu_rd, alu_data carry the result
//   ld_issue_valid    a load to ld_issue_rd was issued (marks it busy)
//   ld_resp_valid/ready  LSU load-response handshake; ld_resp_rd, ld_resp_data
//   rf_we, rf_rd, rf_rd_data  registered register-file write port
//   busy              outstanding-load scoreboard, busy[0] is always 0
module writeback_ctrl #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_resp_valid,
  output logic        ld_resp_ready,
  input  logic [4:0]  ld_resp_rd,
  input  logic [31:0] ld_resp_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_rd_data,
  output logic [31:0] busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(DEPTH - 1);
  localparam logic [STV_W-1:0] STARVE_MAX  = STV_W'(STARVE_LIMIT);

  logic [4:0]       fifo_rd   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  // Remembers whether the write currently on rf_* came from the load FIFO,
  // since only load writes retire a scoreboard entry.
  logic             rf_from_load;

  logic             fifo_empty;
  logic             force_load;
  logic             alu_win;
  logic             pop;
  logic             push;
  logic [31:0]      busy_next;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Arbitration and handshakes. Both ready outputs depend only on registered
  // state and rst, so neither has a combinational path from a valid input.
  // Responses to x0 complete the handshake but are never enqueued.
  always_comb begin
    fifo_empty    = (count == '0);
    force_load    = !fifo_empty && (starve_cnt == STARVE_MAX);
    alu_ready     = !rst && !force_load;
    ld_resp_ready = !rst && (count < DEPTH_C);
    alu_win       = alu_valid && alu_ready;
    pop           = !rst && !alu_win && !fifo_empty;
    push          = ld_resp_valid && ld_resp_ready && (ld_resp_rd != 5'd0);
  end

  // FIFO payload storage. Contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= ld_resp_rd;
      fifo_data[tail] <= ld_resp_data;
    end
  end

  // FIFO pointers, occupancy and the starvation counter. A push into an empty
  // FIFO is not visible to the arbiter until the next cycle (no bypass).
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        tail <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if (alu_win && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Registered write port. With no winner the index and data hold, only the
  // enable drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_rd        <= 5'd0;
      rf_rd_data   <= 32'd0;
      rf_from_load <= 1'b0;
    end else if (alu_win) begin
      rf_we        <= (alu_rd != 5'd0);
      rf_rd        <= alu_rd;
      rf_rd_data   <= alu_data;
      rf_from_load <= 1'b0;
    end else if (pop) begin
      rf_we        <= 1'b1;
      rf_rd        <= fifo_rd[head];
      rf_rd_data   <= fifo_data[head];
      rf_from_load <= 1'b1;
    end else begin
      rf_we        <= 1'b0;
      rf_from_load <= 1'b0;
    end
  end

  // Scoreboard update. The clear lands on the same edge the register file
  // commits the load data. Applying the set after the clear makes a new issue
  // to the same register win a collision.
  always_comb begin
    busy_next = busy;
    if (rf_we && rf_from_load) begin
      busy_next[rf_rd] = 1'b0;
    end
    if (ld_issue_valid && (ld_issue_rd != 5'd0)) begin
      busy_next[ld_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule
